// File: rtl/ddr_avl_arbiter_if.sv
// Requester-side and Avalon-side signal bundle for the two-port DDR arbiter.
// The master modport is the arbiter's own view; slave is the surrounding system.
interface ddr_avl_arbiter_if #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 128
) ();
   logic [1:0]             req_read;
   logic [1:0]             req_write;
   logic [1:0][ADDR_W-1:0] req_address;
   logic [1:0][DATA_W-1:0] req_writedata;
   logic [1:0]             req_wait_request_n;
   logic [1:0]             req_readdatavalid;
   logic [DATA_W-1:0]      req_readdata;

   logic [ADDR_W-1:0]      avl_address;
   logic                   avl_read;
   logic                   avl_write;
   logic                   avl_burstbegin;
   logic [DATA_W-1:0]      avl_writedata;
   logic                   avl_wait_request_n;
   logic                   avl_readdatavalid;
   logic [DATA_W-1:0]      avl_readdata;

   logic [1:0]             grant;
   logic                   err;

   modport master (
      input  req_read, req_write, req_address, req_writedata,
      input  avl_wait_request_n, avl_readdatavalid, avl_readdata,
      output req_wait_request_n, req_readdatavalid, req_readdata,
      output avl_address, avl_read, avl_write, avl_burstbegin, avl_writedata,
      output grant, err
   );

   modport slave (
      output req_read, req_write, req_address, req_writedata,
      output avl_wait_request_n, avl_readdatavalid, avl_readdata,
      input  req_wait_request_n, req_readdatavalid, req_readdata,
      input  avl_address, avl_read, avl_write, avl_burstbegin, avl_writedata,
      input  grant, err
   );
endinterface

// File: rtl/ddr_avl_arbiter.sv
// Two-requester arbiter onto one Avalon-MM DDR port, one outstanding command at a time.
// Define DDR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
//
// state     | meaning
// IDLE      | no owner; arbitrate among pending requesters
// ISSUE     | command on avl_*, held until avl_wait_request_n
// WAIT_DATA | read accepted; waiting for avl_readdatavalid
module ddr_avl_arbiter #(
   parameter int ADDR_W = 26,
   parameter int DATA_W = 128
) (
   input  logic              iCLK,
   input  logic              reset,
   ddr_avl_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

   state_t            state;
   logic [1:0]        grant_q;
   logic              err_q;
   logic              rd_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        pending;
   logic              win;
`ifndef DDR_ARB_FIXED_PRIO_EN
   logic              last;
`endif

   always_comb begin
      pending = bus.req_read | bus.req_write;
`ifdef DDR_ARB_FIXED_PRIO_EN
      win = ~pending[0];
`else
      win = (&pending) ? ~last : pending[1];
`endif
   end

   always_ff @(posedge iCLK or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         grant_q <= 2'b00;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
         last    <= 1'b1;
`endif
      end else begin
         // data returning outside WAIT_DATA belongs to nobody (e.g. a read orphaned by reset)
         if (bus.avl_readdatavalid && (state != WAIT_DATA))
            err_q <= 1'b1;
         case (state)
            IDLE: begin
               if (|pending) begin
                  grant_q <= win ? 2'b10 : 2'b01;
                  addr_q  <= bus.req_address[win];
                  wdata_q <= bus.req_writedata[win];
                  wr_q    <= bus.req_write[win];
                  rd_q    <= ~bus.req_write[win];
`ifndef DDR_ARB_FIXED_PRIO_EN
                  last    <= win;
`endif
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.avl_wait_request_n) begin
                  rd_q <= 1'b0;
                  wr_q <= 1'b0;
                  if (wr_q) begin
                     grant_q <= 2'b00;
                     state   <= IDLE;
                  end else begin
                     state   <= WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               if (bus.avl_readdatavalid) begin
                  grant_q <= 2'b00;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.avl_address        = addr_q;
   assign bus.avl_writedata      = wdata_q;
   assign bus.avl_read           = rd_q;
   assign bus.avl_write          = wr_q;
   assign bus.avl_burstbegin     = rd_q | wr_q;
   assign bus.grant              = grant_q;
   assign bus.err                = err_q;
   assign bus.req_readdata       = bus.avl_readdata;
   assign bus.req_wait_request_n = (state == ISSUE) ? (grant_q & {2{bus.avl_wait_request_n}}) : 2'b00;
   assign bus.req_readdatavalid  = (state == WAIT_DATA) ? (grant_q & {2{bus.avl_readdatavalid}}) : 2'b00;

endmodule

// File: tb/tb_ddr_avl_arbiter.sv
// Directed bench for ddr_avl_arbiter: held reads, read return, write, R+W priority,
// reset during WAIT_DATA, and round-robin or fixed-priority granting.
module tb_ddr_avl_arbiter;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_bad;
   logic [1:0] exp_g [4];

   ddr_avl_arbiter_if #(.ADDR_W(26), .DATA_W(128)) bus ();

   ddr_avl_arbiter #(.ADDR_W(26), .DATA_W(128)) dut (
      .iCLK  (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rd_txn(input logic [1:0] eg);
      int n;
      n = 0;
      while (bus.avl_read !== 1'b1 && n < 8) begin
         tick;
         n++;
      end
      check("rr_issue", n < 8, 1);
      check("rr_grant", bus.grant, eg);
      check("rr_accept", bus.req_wait_request_n, eg);
      tick;
      bus.avl_readdatavalid = 1'b1;
      bus.avl_readdata      = {64{eg}};
      #1;
      check("rr_rdv", bus.req_readdatavalid, eg);
      tick;
      bus.avl_readdatavalid = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
`ifdef DDR_ARB_FIXED_PRIO_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
      rst                    = 1'b1;
      bus.req_read           = 2'b00;
      bus.req_write          = 2'b00;
      bus.req_address        = '0;
      bus.req_writedata      = '0;
      bus.avl_wait_request_n = 1'b0;
      bus.avl_readdatavalid  = 1'b0;
      bus.avl_readdata       = '0;
      tick;
      tick;
      check("rst_grant", bus.grant, 2'b00);
      check("rst_err", bus.err, 1'b0);
      check("rst_rd", bus.avl_read, 1'b0);
      check("rst_wr", bus.avl_write, 1'b0);
      check("rst_bb", bus.avl_burstbegin, 1'b0);
      rst = 1'b0;

      // read held through three wait cycles, then returned two cycles after accept
      bus.req_address[0] = 26'h10;
      bus.req_read       = 2'b01;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i == 3) begin
            bus.avl_wait_request_n = 1'b1;
            #1;
         end
         check("a_rd", bus.avl_read, 1'b1);
         check("a_addr", bus.avl_address, 26'h10);
         check("a_accept", bus.req_wait_request_n, (i == 3) ? 2'b01 : 2'b00);
      end
      tick;
      bus.req_read           = 2'b00;
      bus.avl_wait_request_n = 1'b0;
      #1;
      check("a_rd_off", bus.avl_read, 1'b0);
      check("a_accept_off", bus.req_wait_request_n, 2'b00);
      check("a_wait_grant", bus.grant, 2'b01);
      check("a_rdv_early", bus.req_readdatavalid, 2'b00);
      tick;
      bus.avl_readdata      = {16{8'hA5}};
      bus.avl_readdatavalid = 1'b1;
      #1;
      check("a_rdv", bus.req_readdatavalid, 2'b01);
      check("a_rdata", bus.req_readdata, {16{8'hA5}});
      tick;
      bus.avl_readdatavalid = 1'b0;
      #1;
      check("a_rdv_off", bus.req_readdatavalid, 2'b00);
      check("a_idle_grant", bus.grant, 2'b00);
      check("a_err", bus.err, 1'b0);

      // write from requester 1 at top of address space
      bus.req_address[1]   = 26'h3FFFFFF;
      bus.req_writedata[1] = 128'h1234;
      bus.req_write        = 2'b10;
      tick;
      check("w_wr", bus.avl_write, 1'b1);
      check("w_rd", bus.avl_read, 1'b0);
      check("w_addr", bus.avl_address, 26'h3FFFFFF);
      check("w_data", bus.avl_writedata, 128'h1234);
      check("w_grant", bus.grant, 2'b10);
      check("w_bb", bus.avl_burstbegin, 1'b1);
      bus.avl_wait_request_n = 1'b1;
      #1;
      check("w_accept", bus.req_wait_request_n, 2'b10);
      tick;
      bus.req_write          = 2'b00;
      bus.avl_wait_request_n = 1'b0;
      #1;
      check("w_wr_off", bus.avl_write, 1'b0);
      check("w_idle_grant", bus.grant, 2'b00);
      check("w_rdv", bus.req_readdatavalid, 2'b00);

      // read+write on one requester: write first, read follows as a new request
      bus.req_address[0]     = 26'h20;
      bus.req_writedata[0]   = 128'hBEEF;
      bus.req_read           = 2'b01;
      bus.req_write          = 2'b01;
      bus.avl_wait_request_n = 1'b1;
      tick;
      check("rw_wr", bus.avl_write, 1'b1);
      check("rw_rd", bus.avl_read, 1'b0);
      tick;
      bus.req_write = 2'b00;
      #1;
      check("rw_idle", bus.grant, 2'b00);
      tick;
      check("rw_rd2", bus.avl_read, 1'b1);
      check("rw_addr", bus.avl_address, 26'h20);
      tick;
      bus.req_read = 2'b00;
      check("rw_wait_grant", bus.grant, 2'b01);

      // reset while the read is outstanding; its late data must only raise err
      rst = 1'b1;
      #1;
      check("r_grant", bus.grant, 2'b00);
      check("r_addr", bus.avl_address, 26'h0);
      check("r_wdata", bus.avl_writedata, 128'h0);
      tick;
      rst                   = 1'b0;
      bus.avl_readdatavalid = 1'b1;
      #1;
      check("r_rdv", bus.req_readdatavalid, 2'b00);
      tick;
      bus.avl_readdatavalid = 1'b0;
      #1;
      check("r_err", bus.err, 1'b1);
      tick;
      check("r_err_sticky", bus.err, 1'b1);

      // both requesters reading continuously from a fresh reset
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("rr_err_clr", bus.err, 1'b0);
      bus.req_read = 2'b11;
      for (int k = 0; k < 4; k++) rd_txn(exp_g[k]);
      bus.req_read = 2'b10;
      rd_txn(2'b10);
      bus.req_read = 2'b00;
      check("rr_err", bus.err, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
